// File: rtl/if_id_fetch.sv
// if_id_fetch: instruction-fetch stage with the IF/ID pipeline register.
// Owns the PC, drives a request/ready instruction-memory port and hands each
// fetched word (with PC+4 and pre-decoded register fields) to decode.
// Optional macro IF_ID_PERF_CNT_EN adds saturating stall/flush cycle counters.
module if_id_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ID_Hazard_lwstall,
   input  logic        ID_Hazard_Branch,
   input  logic [31:0] branch_addr_in,
   input  logic        Jump_in,
   input  logic [31:0] jump_addr_in,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic        IF_ID_valid,
   output logic [31:0] instr_out,
   output logic [31:0] PC_plus4_out,
   output logic [4:0]  IF_ID_RegisterRs_out,
   output logic [4:0]  IF_ID_RegisterRt_out,
   output logic [4:0]  IF_ID_RegisterRd_out,
   output logic [5:0]  IF_ID_funct_out
`ifdef IF_ID_PERF_CNT_EN
   ,
   output logic [15:0] stall_cycles_out,
   output logic [15:0] flush_count_out
`endif
);

   typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] buf_q, buf_d;
   logic [31:0] pend_q, pend_d;
   logic        valid_q, valid_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;

   logic        redirect;
   logic [31:0] target;
   logic [31:0] pc_plus4;

   assign redirect = ID_Hazard_Branch | Jump_in;
   assign target   = (ID_Hazard_Branch ? branch_addr_in : jump_addr_in) & ~32'h3;
   assign pc_plus4 = pc_q + 32'd4;

   // Next-state and datapath: redirect beats stall; a word returning while a
   // redirect is pending (DROP) is thrown away and the latest target is used.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      buf_d   = buf_q;
      pend_d  = pend_q;
      valid_d = valid_q;
      instr_d = instr_q;
      pc4_d   = pc4_q;
      case (state_q)
         IDLE: begin
            state_d = FETCH;
         end
         FETCH: begin
            if (redirect) begin
               valid_d = 1'b0;
               instr_d = 32'h0;
               if (imem_ready) begin
                  pc_d = target;
               end else begin
                  pend_d  = target;
                  state_d = DROP;
               end
            end else if (imem_ready) begin
               pc_d = pc_plus4;
               if (ID_Hazard_lwstall) begin
                  buf_d   = imem_rdata;
                  state_d = HOLD;
               end else begin
                  valid_d = 1'b1;
                  instr_d = imem_rdata;
                  pc4_d   = pc_plus4;
               end
            end else if (!ID_Hazard_lwstall) begin
               valid_d = 1'b0;
               instr_d = 32'h0;
            end
         end
         HOLD: begin
            if (redirect) begin
               valid_d = 1'b0;
               instr_d = 32'h0;
               buf_d   = 32'h0;
               pc_d    = target;
               state_d = FETCH;
            end else if (!ID_Hazard_lwstall) begin
               valid_d = 1'b1;
               instr_d = buf_q;
               pc4_d   = pc_q;
               buf_d   = 32'h0;
               state_d = FETCH;
            end
         end
         DROP: begin
            if (redirect) begin
               valid_d = 1'b0;
               instr_d = 32'h0;
               if (imem_ready) begin
                  pc_d    = target;
                  state_d = FETCH;
               end else begin
                  pend_d = target;
               end
            end else if (imem_ready) begin
               pc_d    = pend_q;
               state_d = FETCH;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, PC, skid buffer and IF/ID register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         buf_q   <= 32'h0;
         pend_q  <= 32'h0;
         valid_q <= 1'b0;
         instr_q <= 32'h0;
         pc4_q   <= 32'h0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         buf_q   <= buf_d;
         pend_q  <= pend_d;
         valid_q <= valid_d;
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
      end
   end

   assign imem_req             = (state_q == FETCH) || (state_q == DROP);
   assign imem_addr            = pc_q;
   assign IF_ID_valid          = valid_q;
   assign instr_out            = instr_q;
   assign PC_plus4_out         = pc4_q;
   assign IF_ID_RegisterRs_out = instr_q[25:21];
   assign IF_ID_RegisterRt_out = instr_q[20:16];
   assign IF_ID_RegisterRd_out = instr_q[15:11];
   assign IF_ID_funct_out      = instr_q[5:0];

`ifdef IF_ID_PERF_CNT_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic [15:0] flush_cnt_q, flush_cnt_d;

   // Saturating event counters.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (ID_Hazard_lwstall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
      if (redirect && (flush_cnt_q != 16'hFFFF)) flush_cnt_d = flush_cnt_q + 16'd1;
   end

   // Counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q <= 16'h0;
         flush_cnt_q <= 16'h0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cycles_out = stall_cnt_q;
   assign flush_count_out  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_fetch.sv
// Testbench for if_id_fetch: directed vector table plus hand-written
// sequences for reset and mid-request reset. Memory returns addr ^ A5A5_0000.
module tb_if_id_fetch;

   logic        clk;
   logic        rst;
   logic        stall, branch, jump, ready;
   logic [31:0] baddr, jaddr;
   logic        imem_req;
   logic [31:0] imem_addr, imem_rdata;
   logic        valid;
   logic [31:0] instr, pc4;
   logic [4:0]  rs, rt, rd;
   logic [5:0]  funct;
`ifdef IF_ID_PERF_CNT_EN
   logic [15:0] stall_cnt, flush_cnt;
`endif

   int nChecks = 0;
   int nFails  = 0;

   if_id_fetch #(.RESET_PC(32'h100)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .ID_Hazard_lwstall    (stall),
      .ID_Hazard_Branch     (branch),
      .branch_addr_in       (baddr),
      .Jump_in              (jump),
      .jump_addr_in         (jaddr),
      .imem_req             (imem_req),
      .imem_addr            (imem_addr),
      .imem_ready           (ready),
      .imem_rdata           (imem_rdata),
      .IF_ID_valid          (valid),
      .instr_out            (instr),
      .PC_plus4_out         (pc4),
      .IF_ID_RegisterRs_out (rs),
      .IF_ID_RegisterRt_out (rt),
      .IF_ID_RegisterRd_out (rd),
      .IF_ID_funct_out      (funct)
`ifdef IF_ID_PERF_CNT_EN
      ,
      .stall_cycles_out     (stall_cnt),
      .flush_count_out      (flush_cnt)
`endif
   );

   assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        stall;
      logic        branch;
      logic [31:0] baddr;
      logic        jump;
      logic [31:0] jaddr;
      logic        ready;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_instr;
      logic [31:0] exp_pc4;
   } vec_t;

   vec_t vecs[22];

   function automatic vec_t mk(input logic s, input logic b, input logic [31:0] ba,
                               input logic j, input logic [31:0] ja, input logic r,
                               input logic er, input logic [31:0] ea, input logic ev,
                               input logic [31:0] ei, input logic [31:0] ep);
      vec_t v;
      v.stall = s; v.branch = b; v.baddr = ba; v.jump = j; v.jaddr = ja; v.ready = r;
      v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_instr = ei; v.exp_pc4 = ep;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      stall  = v.stall;
      branch = v.branch;
      baddr  = v.baddr;
      jump   = v.jump;
      jaddr  = v.jaddr;
      ready  = v.ready;
   endtask

   task automatic checkAll(input string tag, input logic er, input logic [31:0] ea,
                           input logic ev, input logic [31:0] ei, input logic [31:0] ep);
      checkOutput({tag, " imem_req"}, {31'b0, imem_req}, {31'b0, er});
      checkOutput({tag, " imem_addr"}, imem_addr, ea);
      checkOutput({tag, " IF_ID_valid"}, {31'b0, valid}, {31'b0, ev});
      checkOutput({tag, " instr_out"}, instr, ei);
      checkOutput({tag, " PC_plus4_out"}, pc4, ep);
      checkOutput({tag, " fields"}, {5'b0, rs, rt, rd, funct},
                  {5'b0, ei[25:21], ei[20:16], ei[15:11], ei[5:0]});
   endtask

   initial begin
      int expStall;
      int expFlush;
      expStall = 0;
      expFlush = 0;

      // stall br  baddr         jmp jaddr    rdy  req addr          vld instr          pc4
      vecs[0]  = mk(0, 0, 32'h0,        0, 32'h0,   1, 1, 32'h100,      0, 32'h0,        32'h0);
      vecs[1]  = mk(0, 0, 32'h0,        0, 32'h0,   1, 1, 32'h104,      1, 32'hA5A50100, 32'h104);
      vecs[2]  = mk(0, 0, 32'h0,        0, 32'h0,   1, 1, 32'h108,      1, 32'hA5A50104, 32'h108);
      vecs[3]  = mk(1, 0, 32'h0,        0, 32'h0,   1, 0, 32'h10C,      1, 32'hA5A50104, 32'h108);
      vecs[4]  = mk(1, 0, 32'h0,        0, 32'h0,   1, 0, 32'h10C,      1, 32'hA5A50104, 32'h108);
      vecs[5]  = mk(0, 0, 32'h0,        0, 32'h0,   1, 1, 32'h10C,      1, 32'hA5A50108, 32'h10C);
      vecs[6]  = mk(0, 0, 32'h0,        0, 32'h0,   1, 1, 32'h110,      1, 32'hA5A5010C, 32'h110);
      vecs[7]  = mk(0, 1, 32'h400,      0, 32'h0,   1, 1, 32'h400,      0, 32'h0,        32'h110);
      vecs[8]  = mk(0, 0, 32'h0,        0, 32'h0,   1, 1, 32'h404,      1, 32'hA5A50400, 32'h404);
      vecs[9]  = mk(0, 0, 32'h0,        0, 32'h0,   0, 1, 32'h404,      0, 32'h0,        32'h404);
      vecs[10] = mk(0, 0, 32'h0,        0, 32'h0,   1, 1, 32'h408,      1, 32'hA5A50404, 32'h408);
      vecs[11] = mk(0, 0, 32'h0,        1, 32'h200, 0, 1, 32'h408,      0, 32'h0,        32'h408);
      vecs[12] = mk(0, 1, 32'h300,      0, 32'h0,   0, 1, 32'h408,      0, 32'h0,        32'h408);
      vecs[13] = mk(0, 0, 32'h0,        0, 32'h0,   0, 1, 32'h408,      0, 32'h0,        32'h408);
      vecs[14] = mk(0, 0, 32'h0,        0, 32'h0,   1, 1, 32'h300,      0, 32'h0,        32'h408);
      vecs[15] = mk(0, 0, 32'h0,        0, 32'h0,   1, 1, 32'h304,      1, 32'hA5A50300, 32'h304);
      vecs[16] = mk(1, 0, 32'h0,        0, 32'h0,   1, 0, 32'h308,      1, 32'hA5A50300, 32'h304);
      vecs[17] = mk(1, 1, 32'hFFFFFFFC, 0, 32'h0,   1, 1, 32'hFFFFFFFC, 0, 32'h0,        32'h304);
      vecs[18] = mk(0, 0, 32'h0,        0, 32'h0,   1, 1, 32'h0,        1, 32'h5A5AFFFC, 32'h0);
      vecs[19] = mk(0, 0, 32'h0,        0, 32'h0,   1, 1, 32'h4,        1, 32'hA5A50000, 32'h4);
      vecs[20] = mk(1, 0, 32'h0,        0, 32'h0,   0, 1, 32'h4,        1, 32'hA5A50000, 32'h4);
      vecs[21] = mk(0, 0, 32'h0,        0, 32'h0,   1, 1, 32'h8,        1, 32'hA5A50004, 32'h8);

      // Hold reset for two edges and check reset values.
      rst = 1'b0;
      stall = 0; branch = 0; jump = 0; ready = 0; baddr = 0; jaddr = 0;
      repeat (2) @(posedge clk);
      #1;
      checkAll("reset", 1'b0, 32'h100, 1'b0, 32'h0, 32'h0);
`ifdef IF_ID_PERF_CNT_EN
      checkOutput("reset stall_cycles", {16'b0, stall_cnt}, 32'd0);
      checkOutput("reset flush_count", {16'b0, flush_cnt}, 32'd0);
`endif
      rst = 1'b1;

      for (int i = 0; i < 22; i++) begin
         applyStimulus(vecs[i]);
         if (vecs[i].stall) expStall++;
         if (vecs[i].branch || vecs[i].jump) expFlush++;
         @(posedge clk);
         #1;
         checkAll($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_addr,
                  vecs[i].exp_valid, vecs[i].exp_instr, vecs[i].exp_pc4);
      end

`ifdef IF_ID_PERF_CNT_EN
      checkOutput("stall_cycles", {16'b0, stall_cnt}, expStall);
      checkOutput("flush_count", {16'b0, flush_cnt}, expFlush);
`endif

      // Reset asserted while a request is outstanding takes effect at once.
      stall = 0; branch = 0; jump = 0; ready = 0;
      #3;
      rst = 1'b0;
      #1;
      checkAll("midreset", 1'b0, 32'h100, 1'b0, 32'h0, 32'h0);
`ifdef IF_ID_PERF_CNT_EN
      checkOutput("midreset stall_cycles", {16'b0, stall_cnt}, 32'd0);
      checkOutput("midreset flush_count", {16'b0, flush_cnt}, 32'd0);
`endif

      // Restart from reset and stream again.
      @(posedge clk);
      #1;
      rst = 1'b1;
      ready = 1'b1;
      @(posedge clk);
      #1;
      checkAll("restart0", 1'b1, 32'h100, 1'b0, 32'h0, 32'h0);
      @(posedge clk);
      #1;
      checkAll("restart1", 1'b1, 32'h104, 1'b1, 32'hA5A50100, 32'h104);
      @(posedge clk);
      #1;
      checkAll("restart2", 1'b1, 32'h108, 1'b1, 32'hA5A50104, 32'h108);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
